// File: rtl/data_memory_n_port.sv
// data_memory_n_port: NUM_PORTS-port word memory with post-reset zero-fill,
// lowest-port-wins write collisions, out-of-range flagging and 1-cycle
// registered responses. Define DMEM_OUT_REG_EN for an extra output stage
// (2-cycle latency, same throughput).
module data_memory_n_port #(
  parameter int NUM_PORTS  = 4,
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 16,
  parameter int DEPTH      = 1000
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NUM_PORTS-1:0]             req,
  input  logic [NUM_PORTS-1:0]             we,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0]  addr,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0]  data_in,
  output logic [NUM_PORTS*DATA_WIDTH-1:0]  q,
  output logic [NUM_PORTS-1:0]             rvalid,
  output logic [NUM_PORTS-1:0]             err,
  output logic                             init_done
);

  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_WIDTH-1:0] LAST  = ADDR_WIDTH'(DEPTH - 1);
  localparam logic [ADDR_WIDTH:0]   LIMIT = (ADDR_WIDTH+1)'(DEPTH);

  typedef enum logic {FILL, READY} state_e;

  state_e                                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]                   fill_cnt_q, fill_cnt_d;
  logic [DATA_WIDTH-1:0]                   mem [DEPTH];

  logic [NUM_PORTS-1:0][ADDR_WIDTH-1:0]    addr_a;
  logic [NUM_PORTS-1:0][DATA_WIDTH-1:0]    din_a, rd_a, q_d, q_q;
  logic [NUM_PORTS-1:0]                    acc, inr, wr, lost, err_d;
  logic [NUM_PORTS-1:0]                    rvalid_q, err_q;

  assign addr_a    = addr;
  assign din_a     = data_in;
  assign init_done = (state_q == READY);

  // Per-port qualification; reads see the array before this cycle's writes.
  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
    assign acc[p]   = req[p] & init_done;
    assign inr[p]   = ({1'b0, addr_a[p]} < LIMIT);
    assign wr[p]    = acc[p] & we[p] & inr[p];
    assign rd_a[p]  = inr[p] ? mem[addr_a[p][IW-1:0]] : '0;
    assign q_d[p]   = we[p] ? din_a[p] : rd_a[p];
    assign err_d[p] = ~inr[p] | lost[p];
  end

  // A write loses if any lower-indexed port writes the same in-range word.
  always_comb begin
    lost = '0;
    for (int p = 1; p < NUM_PORTS; p++)
      for (int j = 0; j < p; j++)
        if (wr[p] && wr[j] && (addr_a[j] == addr_a[p])) lost[p] = 1'b1;
  end

  // FSM state and fill counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= FILL;
      fill_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      fill_cnt_q <= fill_cnt_d;
    end
  end

  // Next state: sweep every address once, then stay READY until reset.
  always_comb begin
    state_d    = state_q;
    fill_cnt_d = fill_cnt_q;
    case (state_q)
      FILL: begin
        fill_cnt_d = fill_cnt_q + ADDR_WIDTH'(1);
        if (fill_cnt_q == LAST) state_d = READY;
      end
      READY:   state_d = READY;
      default: state_d = FILL;
    endcase
  end

  // Array update: zero-fill while filling, winning port writes afterwards.
  always_ff @(posedge clk) begin
    if (state_q == FILL) begin
      mem[fill_cnt_q[IW-1:0]] <= '0;
    end else begin
      for (int p = 0; p < NUM_PORTS; p++)
        if (wr[p] && !lost[p]) mem[addr_a[p][IW-1:0]] <= din_a[p];
    end
  end

  // Response register: q holds when no request is accepted on that port.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_q      <= '0;
      rvalid_q <= '0;
      err_q    <= '0;
    end else begin
      rvalid_q <= acc;
      err_q    <= acc & err_d;
      for (int p = 0; p < NUM_PORTS; p++)
        if (acc[p]) q_q[p] <= q_d[p];
    end
  end

`ifdef DMEM_OUT_REG_EN
  logic [NUM_PORTS-1:0][DATA_WIDTH-1:0] q2_q;
  logic [NUM_PORTS-1:0]                 rvalid2_q, err2_q;

  // Second output stage; plain copy keeps ordering and hold behaviour.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q2_q      <= '0;
      rvalid2_q <= '0;
      err2_q    <= '0;
    end else begin
      q2_q      <= q_q;
      rvalid2_q <= rvalid_q;
      err2_q    <= err_q;
    end
  end

  assign q      = q2_q;
  assign rvalid = rvalid2_q;
  assign err    = err2_q;
`else
  assign q      = q_q;
  assign rvalid = rvalid_q;
  assign err    = err_q;
`endif

endmodule

// File: doc/data_memory_n_port.md
Name: data_memory_n_port

Overview:
- Parametrised multi-port data memory shared by the matrix-multiplication cores. It generalises the two-port word RAM to NUM_PORTS ports with configurable width and depth.
- Adds per-port request/valid handshakes, deterministic write-collision priority, out-of-range detection and a post-reset zero-fill sequencer.
- Sits between the core array and the shared operand/result storage.

Parameters:
- NUM_PORTS, 4: number of independent access ports (1..8).
- DATA_WIDTH, 16: word width in bits.
- ADDR_WIDTH, 16: address width in bits.
- DEPTH, 1000: number of words. Valid addresses are 0..DEPTH-1. DEPTH <= 2^ADDR_WIDTH.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- req  in  NUM_PORTS  per-port access request.
- we  in  NUM_PORTS  per-port write enable; qualified by req.
- addr  in  NUM_PORTS*ADDR_WIDTH  packed addresses; port p at [p*ADDR_WIDTH +: ADDR_WIDTH].
- data_in  in  NUM_PORTS*DATA_WIDTH  packed write data.
- q  out  NUM_PORTS*DATA_WIDTH  packed read data.
- rvalid  out  NUM_PORTS  q valid for port p; one pulse per accepted request.
- err  out  NUM_PORTS  out-of-range or lost-write flag; qualified by rvalid.
- init_done  out  1  high once zero-fill is complete; requests are accepted only while high.

Behaviour:
- Reset (async, rst=1): q=0, rvalid=0, err=0, init_done=0, fill counter=0, FSM=FILL. The array is not cleared asynchronously.
- FSM FILL:
  - Writes 0 to address fill_cnt each cycle; fill_cnt increments by 1.
  - When fill_cnt == DEPTH-1 is written, go to READY next cycle and set init_done=1.
  - Fill takes exactly DEPTH cycles after rst falls.
  - In FILL, req is ignored: no rvalid, no writes.
- FSM READY: terminal until rst. rst asserted mid-fill or mid-operation restarts FILL from address 0.
- Accepted request: req[p]=1 and init_done=1 at edge N. The response (rvalid[p]=1, q, err) is registered at edge N+1. Latency is 1 cycle.
- rvalid[p] is high for exactly one cycle per accepted request. Back-to-back requests give back-to-back rvalid at full throughput on every port.
- Write (we[p]=1): the word is stored. q[p] returns data_in[p] (write-through).
- Read (we[p]=0): q[p] returns the array content before any same-cycle writes (read-before-write across ports).
- Write collision (two or more ports write the same in-range address in one cycle):
  - The lowest port index wins.
  - Losing ports get err=1, and their q echoes their own data_in.
- Out-of-range (addr >= DEPTH):
  - Write is dropped.
  - A read returns q=0.
  - err=1 with rvalid=1.
- Non-accepted cycles: q holds its last value, rvalid=0, err=0.
- Widths: addresses compare unsigned. No arithmetic on data.

Optional Feature:
- Macro DMEM_OUT_REG_EN adds a second output register stage on q/rvalid/err.
  - Defined: latency is 2 cycles, throughput is unchanged, and all collision/order rules are preserved. The extra stage resets to 0.
  - Undefined: latency is 1 cycle as above.

Test Plan:
- Reset then idle, DEPTH=1000 -> init_done rises exactly 1000 cycles after rst falls. Reads of addr 0, 500 and 999 return q=0, err=0.
- Port0 writes 0xBEEF to addr 10, then port1 reads addr 10 next cycle -> port0 q=0xBEEF the cycle after the write. Port1 q=0xBEEF with rvalid=1 one cycle after its request.
- Same cycle: port0 writes 0x1111 and port2 writes 0x2222 to addr 20 -> port2 err=1. A subsequent read of addr 20 returns 0x1111.
- Same cycle: port1 writes 0x00AA to addr 5 (holding 0x0055) while port3 reads addr 5 -> port3 q=0x0055. The next read of addr 5 returns 0x00AA.
- Port0 reads addr 1000 and port1 writes 0xFFFF to addr 1200 -> both get rvalid=1 and err=1, and port0 q=0. No in-range word changes.
- Assert rst at fill cycle 300, release -> init_done low and outputs cleared immediately. Fill restarts at 0 and init_done rises 1000 cycles after release.
